// File: rtl/max_track_pkg.sv
// Shared definitions for the streaming arg-max tracker: default widths,
// a signedness-aware comparison helper and the default-width result record.
package max_track_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_SIGNED = 0;
    localparam int DEF_CNT_W  = 8;

    // Widest value the comparison helper accepts; callers zero-extend into it.
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] max;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_CNT_W-1:0]  count;
        logic                  ovf;
    } max_result_t;

    // Two's-complement order equals unsigned order once the sign bit is inverted.
    function automatic logic greater_than(
        input logic                  is_signed,
        input int unsigned           width,
        input logic [MAX_DATA_W-1:0] a,
        input logic [MAX_DATA_W-1:0] b
    );
        logic [MAX_DATA_W-1:0] bias;
        bias = '0;
        if (is_signed)
            bias[width-1] = 1'b1;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/max_cmp_sel.sv
// Two-input compare-and-select: the candidate replaces the incumbent only when
// strictly greater, or unconditionally when it is the first item of a frame.
module max_cmp_sel
    import max_track_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int SIGNED = DEF_SIGNED
) (
    input  logic [DATA_W-1:0] inc_val,
    input  logic [TAG_W-1:0]  inc_tag,
    input  logic [DATA_W-1:0] cand_val,
    input  logic [TAG_W-1:0]  cand_tag,
    input  logic              first,
    output logic [DATA_W-1:0] sel_val,
    output logic [TAG_W-1:0]  sel_tag
);

    logic [MAX_DATA_W-1:0] inc_ext;
    logic [MAX_DATA_W-1:0] cand_ext;
    logic                  cand_wins;

    always_comb begin
        inc_ext               = '0;
        cand_ext              = '0;
        inc_ext[DATA_W-1:0]   = inc_val;
        cand_ext[DATA_W-1:0]  = cand_val;
        // Ties keep the incumbent so the earliest maximum survives.
        cand_wins = first || greater_than(SIGNED != 0, DATA_W, cand_ext, inc_ext);
        sel_val   = cand_wins ? cand_val : inc_val;
        sel_tag   = cand_wins ? cand_tag : inc_tag;
    end

endmodule

// File: rtl/max_track_stream.sv
// Streaming arg-max unit: accumulates (value, tag) items over a frame and
// emits max, tag, saturating item count and overflow once per frame.
module max_track_stream
    import max_track_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int SIGNED = DEF_SIGNED,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CLEAR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [TAG_W-1:0]  IN_TAG,
    input  logic              IN_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_MAX,
    output logic [TAG_W-1:0]  OUT_TAG,
    output logic [CNT_W-1:0]  OUT_COUNT,
    output logic              OUT_OVF,
    output logic              BUSY
);

    logic [DATA_W-1:0] acc_max_reg, acc_max_next;
    logic [TAG_W-1:0]  acc_tag_reg, acc_tag_next;
    logic [CNT_W-1:0]  acc_cnt_reg, acc_cnt_next;
    logic              acc_ovf_reg, acc_ovf_next;
    logic              acc_any_reg, acc_any_next;

    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_max_reg, out_max_next;
    logic [TAG_W-1:0]  out_tag_reg, out_tag_next;
    logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
    logic              out_ovf_reg, out_ovf_next;

    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] sel_val;
    logic [TAG_W-1:0]  sel_tag;
    logic              cnt_sat;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_inc;

    assign in_ready = !CLEAR && (!out_valid_reg || OUT_READY);
    assign accept   = IN_VALID && in_ready;
    assign cnt_sat  = &acc_cnt_reg;
    assign cnt_inc  = cnt_sat ? acc_cnt_reg : acc_cnt_reg + CNT_W'(1);
    assign ovf_inc  = acc_ovf_reg || cnt_sat;

    max_cmp_sel #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .inc_val  (acc_max_reg),
        .inc_tag  (acc_tag_reg),
        .cand_val (IN_DATA),
        .cand_tag (IN_TAG),
        .first    (!acc_any_reg),
        .sel_val  (sel_val),
        .sel_tag  (sel_tag)
    );

    always_comb begin
        acc_max_next   = acc_max_reg;
        acc_tag_next   = acc_tag_reg;
        acc_cnt_next   = acc_cnt_reg;
        acc_ovf_next   = acc_ovf_reg;
        acc_any_next   = acc_any_reg;
        out_valid_next = out_valid_reg;
        out_max_next   = out_max_reg;
        out_tag_next   = out_tag_reg;
        out_cnt_next   = out_cnt_reg;
        out_ovf_next   = out_ovf_reg;

        // A consumed result drops unless a new one replaces it below.
        if (out_valid_reg && OUT_READY)
            out_valid_next = 1'b0;

        if (CLEAR) begin
            acc_any_next = 1'b0;
            acc_cnt_next = '0;
            acc_ovf_next = 1'b0;
        end else if (accept) begin
            if (IN_LAST) begin
                out_valid_next = 1'b1;
                out_max_next   = sel_val;
                out_tag_next   = sel_tag;
                out_cnt_next   = cnt_inc;
                out_ovf_next   = ovf_inc;
                acc_any_next   = 1'b0;
                acc_cnt_next   = '0;
                acc_ovf_next   = 1'b0;
            end else begin
                acc_max_next = sel_val;
                acc_tag_next = sel_tag;
                acc_cnt_next = cnt_inc;
                acc_ovf_next = ovf_inc;
                acc_any_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_max_reg   <= '0;
            acc_tag_reg   <= '0;
            acc_cnt_reg   <= '0;
            acc_ovf_reg   <= 1'b0;
            acc_any_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_max_reg   <= '0;
            out_tag_reg   <= '0;
            out_cnt_reg   <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            acc_max_reg   <= acc_max_next;
            acc_tag_reg   <= acc_tag_next;
            acc_cnt_reg   <= acc_cnt_next;
            acc_ovf_reg   <= acc_ovf_next;
            acc_any_reg   <= acc_any_next;
            out_valid_reg <= out_valid_next;
            out_max_reg   <= out_max_next;
            out_tag_reg   <= out_tag_next;
            out_cnt_reg   <= out_cnt_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_reg;
    assign OUT_MAX   = out_max_reg;
    assign OUT_TAG   = out_tag_reg;
    assign OUT_COUNT = out_cnt_reg;
    assign OUT_OVF   = out_ovf_reg;
    assign BUSY      = acc_any_reg;

endmodule

// File: tb/tb_max_track_stream.sv
// Bench for max_track_stream: three instances (unsigned, signed, 2-bit count)
// share one stimulus stream and are checked against a frame-level model.
module tb_max_track_stream;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CLEAR = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_DATA = '0;
    logic [2:0]  IN_TAG = '0;
    logic        IN_LAST = 1'b0;
    logic        OUT_READY = 1'b0;

    logic [2:0]        o_valid, o_ready, o_ovf, o_busy;
    logic [2:0][15:0]  o_max;
    logic [2:0][2:0]   o_tag;
    logic [2:0][7:0]   o_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int CW = (gi == 2) ? 2 : 8;
        logic [CW-1:0] cnt;
        max_track_stream #(
            .DATA_W (16),
            .TAG_W  (3),
            .SIGNED ((gi == 1) ? 1 : 0),
            .CNT_W  (CW)
        ) u_dut (
            .CLK       (CLK),
            .nRST      (nRST),
            .CLEAR     (CLEAR),
            .IN_VALID  (IN_VALID),
            .IN_READY  (o_ready[gi]),
            .IN_DATA   (IN_DATA),
            .IN_TAG    (IN_TAG),
            .IN_LAST   (IN_LAST),
            .OUT_VALID (o_valid[gi]),
            .OUT_READY (OUT_READY),
            .OUT_MAX   (o_max[gi]),
            .OUT_TAG   (o_tag[gi]),
            .OUT_COUNT (cnt),
            .OUT_OVF   (o_ovf[gi]),
            .BUSY      (o_busy[gi])
        );
        assign o_cnt[gi] = 8'(cnt);
    end

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [15:0] d;
        logic [2:0]  t;
    } item_t;

    item_t       frame[$];
    logic        e_valid;
    logic [15:0] e_max[3];
    logic [2:0]  e_tag[3];
    int          e_cnt[3];
    logic        e_ovf[3];
    int          cnt_limit[3] = '{255, 255, 3};
    bit          is_signed[3] = '{0, 1, 0};

    function automatic bit bigger(bit sgn, logic [15:0] a, logic [15:0] b);
        if (sgn)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            frame.delete();
            e_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                e_max[k] = '0; e_tag[k] = '0; e_cnt[k] = 0; e_ovf[k] = 1'b0;
            end
        end else begin
            bit rdy, took_last;
            rdy       = !CLEAR && (!e_valid || OUT_READY);
            took_last = IN_VALID && rdy && IN_LAST;
            if (e_valid && OUT_READY)
                e_valid = 1'b0;
            if (CLEAR) begin
                frame.delete();
            end else if (IN_VALID && rdy) begin
                item_t it;
                it.d = IN_DATA;
                it.t = IN_TAG;
                frame.push_back(it);
                if (took_last) begin
                    for (int k = 0; k < 3; k++) begin
                        int best;
                        best = 0;
                        for (int i = 1; i < frame.size(); i++)
                            if (bigger(is_signed[k], frame[i].d, frame[best].d))
                                best = i;
                        e_max[k] = frame[best].d;
                        e_tag[k] = frame[best].t;
                        e_cnt[k] = (frame.size() > cnt_limit[k]) ? cnt_limit[k] : frame.size();
                        e_ovf[k] = frame.size() > cnt_limit[k];
                    end
                    e_valid = 1'b1;
                    frame.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, 32'(o_valid[k]), 32'(e_valid));
            chk("in_ready",  k, 32'(o_ready[k]), 32'(!CLEAR && (!e_valid || OUT_READY)));
            chk("busy",      k, 32'(o_busy[k]),  32'(frame.size() != 0));
            chk("out_max",   k, 32'(o_max[k]),   32'(e_max[k]));
            chk("out_tag",   k, 32'(o_tag[k]),   32'(e_tag[k]));
            chk("out_count", k, 32'(o_cnt[k]),   32'(e_cnt[k]));
            chk("out_ovf",   k, 32'(o_ovf[k]),   32'(e_ovf[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [15:0] d, input logic [2:0] t,
                       input logic l, input logic ordy, input logic clr);
        IN_VALID  = v;
        IN_DATA   = d;
        IN_TAG    = t;
        IN_LAST   = l;
        OUT_READY = ordy;
        CLEAR     = clr;
        @(posedge CLK);
        $display("cyc t=%0t v=%0b d=%04h tag=%0d last=%0b ordy=%0b clr=%0b -> out_valid=%0b max=%04h tag=%0d cnt=%0d",
                 $time, v, d, t, l, ordy, clr, o_valid[0], o_max[0], o_tag[0], o_cnt[0]);
        #2;
    endtask

    initial begin
        #1;
        chk("rst_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("rst_max",   0, 32'(o_max[0]),   32'd0);
        @(posedge CLK); @(posedge CLK); #2;
        nRST = 1'b1;
        chk("rdy_after_rst", 0, 32'(o_ready[0]), 32'd1);

        // Unsigned/signed frame
        cyc(1, 16'h0010, 3'd1, 0, 1, 0);
        cyc(1, 16'h8000, 3'd2, 0, 1, 0);
        cyc(1, 16'h0005, 3'd3, 1, 1, 0);
        chk("lit_u_max", 0, 32'(o_max[0]), 32'h8000);
        chk("lit_u_tag", 0, 32'(o_tag[0]), 32'd2);
        chk("lit_u_cnt", 0, 32'(o_cnt[0]), 32'd3);
        chk("lit_u_ovf", 0, 32'(o_ovf[0]), 32'd0);
        chk("lit_s_max", 1, 32'(o_max[1]), 32'h0010);
        chk("lit_s_tag", 1, 32'(o_tag[1]), 32'd1);

        // Tie keeps earliest, then single-item frame replacing a consumed result
        cyc(1, 16'h0007, 3'd4, 0, 1, 0);
        cyc(1, 16'h0007, 3'd5, 1, 1, 0);
        chk("lit_tie_tag", 0, 32'(o_tag[0]), 32'd4);
        cyc(1, 16'h0042, 3'd6, 1, 1, 0);
        chk("lit_single_cnt", 0, 32'(o_cnt[0]), 32'd1);
        chk("lit_single_tag", 0, 32'(o_tag[0]), 32'd6);
        chk("lit_single_vld", 0, 32'(o_valid[0]), 32'd1);
        cyc(0, 16'h0000, 3'd0, 0, 1, 0);
        chk("lit_release", 0, 32'(o_valid[0]), 32'd0);

        // Backpressure hold, then release together with a new last item
        cyc(1, 16'h0003, 3'd1, 0, 0, 0);
        cyc(1, 16'h0009, 3'd2, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(1, 16'h7fff, 3'd7, 1, 0, 0);
        chk("lit_hold_max", 0, 32'(o_max[0]), 32'h0009);
        chk("lit_hold_rdy", 0, 32'(o_ready[0]), 32'd0);
        cyc(1, 16'h0100, 3'd3, 1, 1, 0);
        chk("lit_swap_max", 0, 32'(o_max[0]), 32'h0100);
        chk("lit_swap_vld", 0, 32'(o_valid[0]), 32'd1);
        cyc(0, 16'h0000, 3'd0, 0, 1, 0);

        // CLEAR mid-frame discards partial frame and blocks the presented item
        cyc(1, 16'h0050, 3'd2, 0, 1, 0);
        cyc(1, 16'h0060, 3'd3, 0, 1, 0);
        cyc(1, 16'hffff, 3'd5, 1, 1, 1);
        cyc(1, 16'h0001, 3'd0, 1, 1, 0);
        chk("lit_clr_max", 0, 32'(o_max[0]), 32'h0001);
        chk("lit_clr_cnt", 0, 32'(o_cnt[0]), 32'd1);
        // CLEAR while a result is held leaves it untouched
        cyc(1, 16'h0020, 3'd1, 0, 0, 1);
        chk("lit_clr_hold", 0, 32'(o_max[0]), 32'h0001);
        chk("lit_clr_hvld", 0, 32'(o_valid[0]), 32'd1);
        cyc(0, 16'h0000, 3'd0, 0, 1, 0);

        // Five-item frame saturates the 2-bit counter
        for (int i = 1; i <= 5; i++)
            cyc(1, 16'(i), 3'(i), (i == 5), 1, 0);
        chk("lit_sat_cnt", 2, 32'(o_cnt[2]), 32'd3);
        chk("lit_sat_ovf", 2, 32'(o_ovf[2]), 32'd1);
        chk("lit_wide_cnt", 0, 32'(o_cnt[0]), 32'd5);

        // Reset with a pending result
        cyc(0, 16'h0000, 3'd0, 0, 0, 0);
        #1 nRST = 1'b0;
        #1;
        chk("lit_arst_vld", 0, 32'(o_valid[0]), 32'd0);
        chk("lit_arst_cnt", 2, 32'(o_cnt[2]), 32'd0);
        @(posedge CLK); #2 nRST = 1'b1;

        // Reset mid-frame, next frame counts from 1
        cyc(1, 16'h0030, 3'd1, 0, 1, 0);
        cyc(1, 16'h0031, 3'd2, 0, 1, 0);
        nRST = 1'b0;
        #1;
        chk("lit_arst_busy", 0, 32'(o_busy[0]), 32'd0);
        @(posedge CLK); #2 nRST = 1'b1;
        cyc(1, 16'h000a, 3'd3, 0, 1, 0);
        cyc(1, 16'h000b, 3'd4, 1, 1, 0);
        chk("lit_post_cnt", 0, 32'(o_cnt[0]), 32'd2);
        chk("lit_post_tag", 0, 32'(o_tag[0]), 32'd4);
        cyc(0, 16'h0000, 3'd0, 0, 1, 0);
        cyc(0, 16'h0000, 3'd0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
